// File: rtl/task_icd_pkg.sv
// rtl/task_icd_pkg.sv - Task ICD constants, framer state type and length check helper
package task_icd_pkg;

    // Index of the header word that carries the message length in bytes.
    localparam int LEN_IDX       = 1;
    // Smallest legal message: the header words up to and including the length word.
    localparam int HEADER_BYTES  = (LEN_IDX + 1) * 4;
    localparam int MAX_MSG_BYTES = 64;
    localparam int MAX_MSG_WORDS = MAX_MSG_BYTES / 4;
    // Width of a word index inside one message.
    localparam int IDX_W         = $clog2(MAX_MSG_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } framer_state_t;

    // A length is usable only if it is word aligned and inside the legal range.
    function automatic logic len_valid(input logic [31:0] len);
        return (len[1:0] == 2'b00) &&
               (len >= 32'(HEADER_BYTES)) &&
               (len <= 32'(MAX_MSG_BYTES));
    endfunction

endpackage

// File: rtl/task_framer_byte_packer.sv
// rtl/task_framer_byte_packer.sv - Big-endian byte-to-word packer with pad-and-complete
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_fire,
    input  logic [7:0]  byte_data,
    input  logic        pad,
    output logic        word_done,
    output logic [31:0] word_data
);

    logic [31:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] merged;

    // Merge the incoming byte into its big-endian lane; unfilled lanes stay zero so a pad completes cleanly.
    always_comb begin
        merged = sr_q;
        if (byte_fire) begin
            case (cnt_q)
                2'd0:    merged[31:24] = byte_data;
                2'd1:    merged[23:16] = byte_data;
                2'd2:    merged[15:8]  = byte_data;
                default: merged[7:0]   = byte_data;
            endcase
        end
        word_done = (byte_fire && (cnt_q == 2'd3)) || pad;
        word_data = merged;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        if (word_done) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (byte_fire) begin
            sr_d  = merged;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Partial word and byte position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/task_framer.sv
// rtl/task_framer.sv - Byte stream to framed task word stream (timeout flush: TASK_FRAMER_TIMEOUT_EN)
module task_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        asi_byte_ready,
    input  logic        asi_byte_valid,
    input  logic [7:0]  asi_byte_data,
    input  logic        aso_task_ready,
    output logic        aso_task_valid,
    output logic        aso_task_sop,
    output logic        aso_task_eop,
    output logic [31:0] aso_task_data,
    output logic        err_len,
    output logic        err_timeout
);

    import task_icd_pkg::*;

    if ((64'(1) << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_to_w_check
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    framer_state_t    state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [31:0]      data_q, data_d;
    logic             err_len_q, err_len_d;

    logic             byte_ready;
    logic             byte_fire;
    logic             out_free;
    logic             pad;
    logic             word_done;
    logic [31:0]      word_data;
    logic             len_ok;
    logic [IDX_W:0]   len_words;
    logic [IDX_W-1:0] len_last;
    logic             len_hit;
    logic             load_eop;

`ifdef TASK_FRAMER_TIMEOUT_EN
    logic [TO_W-1:0]  gap_q, gap_d;
    logic             err_timeout_q, err_timeout_d;
`endif

    // The output register can take a new word when empty or draining this cycle.
    assign out_free       = ~valid_q | aso_task_ready;
    assign byte_ready     = (state_q != FLUSH) & out_free & ~rst;
    assign byte_fire      = asi_byte_valid & byte_ready;
    assign pad            = (state_q == FLUSH) & out_free;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .byte_fire (byte_fire),
        .byte_data (asi_byte_data),
        .pad       (pad),
        .word_done (word_done),
        .word_data (word_data)
    );

    assign len_ok    = len_valid(word_data);
    assign len_words = word_data[IDX_W+2:2];
    assign len_last  = IDX_W'(len_words - 1'b1);

    // Framing FSM: word indexing, length capture, eop placement and output register loading.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        valid_d    = valid_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        data_d     = data_q;
        err_len_d  = 1'b0;
        len_hit    = 1'b0;
        load_eop   = 1'b0;
`ifdef TASK_FRAMER_TIMEOUT_EN
        err_timeout_d = 1'b0;
        gap_d         = gap_q;
`endif
        if (valid_q && aso_task_ready) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            len_hit = (state_q == HDR) && (word_idx_q == IDX_W'(LEN_IDX));
            if (state_q == FLUSH) begin
                load_eop = 1'b1;
            end else if (len_hit) begin
                if (!len_ok) begin
                    load_eop  = 1'b1;
                    err_len_d = 1'b1;
                end else begin
                    last_idx_d = len_last;
                    load_eop   = (len_last == IDX_W'(LEN_IDX));
                end
            end else if (state_q == BODY) begin
                load_eop = (word_idx_q == last_idx_q);
            end
            valid_d = 1'b1;
            sop_d   = (word_idx_q == '0);
            eop_d   = load_eop;
            data_d  = word_data;
            if (load_eop) begin
                word_idx_d = '0;
                state_d    = IDLE;
            end else begin
                word_idx_d = word_idx_q + 1'b1;
                if (len_hit) begin
                    state_d = BODY;
                end
            end
`ifdef TASK_FRAMER_TIMEOUT_EN
            if (state_q == FLUSH) begin
                err_timeout_d = 1'b1;
            end
`endif
        end else if ((state_q == IDLE) && byte_fire) begin
            state_d = HDR;
        end
`ifdef TASK_FRAMER_TIMEOUT_EN
        // Gap counts idle cycles inside a message; downstream stalls are not the sender's fault.
        if ((state_q == HDR) || (state_q == BODY)) begin
            if (byte_fire) begin
                gap_d = '0;
            end else if (!(valid_q && !aso_task_ready)) begin
                gap_d = gap_q + 1'b1;
                if (gap_d == TO_W'(TIMEOUT_CYCLES)) begin
                    state_d = FLUSH;
                end
            end
        end else begin
            gap_d = '0;
        end
`endif
    end

    // State, counters and the single-entry output word register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            last_idx_q <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            last_idx_q <= last_idx_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            data_q     <= data_d;
            err_len_q  <= err_len_d;
        end
    end

`ifdef TASK_FRAMER_TIMEOUT_EN
    // Inter-byte gap counter and flush error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            gap_q         <= gap_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign asi_byte_ready = byte_ready;
    assign aso_task_valid = valid_q;
    assign aso_task_sop   = sop_q;
    assign aso_task_eop   = eop_q;
    assign aso_task_data  = data_q;
    assign err_len        = err_len_q;

endmodule

// File: tb/tb_task_framer.sv
// tb/tb_task_framer.sv - Directed self-checking bench for task_framer
module tb_task_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        asi_byte_ready;
    logic        asi_byte_valid;
    logic [7:0]  asi_byte_data;
    logic        aso_task_ready;
    logic        aso_task_valid;
    logic        aso_task_sop;
    logic        aso_task_eop;
    logic [31:0] aso_task_data;
    logic        err_len;
    logic        err_timeout;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    word_t wq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_err_len = 0;
    int    n_err_to  = 0;
    int    e0;

    always #5 clk = ~clk;

    task_framer #(
        .TIMEOUT_CYCLES (8),
        .TO_W           (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .asi_byte_ready (asi_byte_ready),
        .asi_byte_valid (asi_byte_valid),
        .asi_byte_data  (asi_byte_data),
        .aso_task_ready (aso_task_ready),
        .aso_task_valid (aso_task_valid),
        .aso_task_sop   (aso_task_sop),
        .aso_task_eop   (aso_task_eop),
        .aso_task_data  (aso_task_data),
        .err_len        (err_len),
        .err_timeout    (err_timeout)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (aso_task_valid && aso_task_ready)
                wq.push_back('{aso_task_data, aso_task_sop, aso_task_eop});
            if (err_len)     n_err_len++;
            if (err_timeout) n_err_to++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        asi_byte_valid = 1'b1;
        asi_byte_data  = b;
        @(negedge clk);
        while (!asi_byte_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!asi_byte_ready) check("byte_accept_bound", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        asi_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] d, input logic s, input logic e);
        word_t w;
        if (wq.size() == 0) begin
            check({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            w = wq.pop_front();
            check(tag, {30'b0, w.sop, w.eop, w.data}, {30'b0, s, e, d});
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_msg16(input logic [31:0] w0, input logic [31:0] w2, input logic [31:0] w3);
        send_word(w0);
        send_word(32'h0000_0010);
        send_word(w2);
        send_word(w3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        asi_byte_valid = 1'b0;
        asi_byte_data  = 8'h00;
        aso_task_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_byte_ready", 64'(asi_byte_ready), 64'd0);
        check("rst_flags", 64'({aso_task_valid, aso_task_sop, aso_task_eop, err_len, err_timeout}), 64'd0);
        check("rst_data", 64'(aso_task_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_byte_ready", 64'(asi_byte_ready), 64'd1);
        @(posedge clk);
        #1;

        // Valid 16-byte message.
        e0 = n_err_len;
        send_msg16(32'h0102_0304, 32'hA0A1_A2A3, 32'hB0B1_B2B3);
        settle();
        check("t1_count", 64'(wq.size()), 64'd4);
        pop_check("t1_w0", 32'h0102_0304, 1'b1, 1'b0);
        pop_check("t1_w1", 32'h0000_0010, 1'b0, 1'b0);
        pop_check("t1_w2", 32'hA0A1_A2A3, 1'b0, 1'b0);
        pop_check("t1_w3", 32'hB0B1_B2B3, 1'b0, 1'b1);
        check("t1_err_len", 64'(n_err_len - e0), 64'd0);

        // Unaligned length cuts at the length word; next bytes open a minimal legal message.
        e0 = n_err_len;
        send_word(32'h1122_3344);
        send_word(32'h0000_0011);
        send_word(32'hC0C1_C2C3);
        send_word(32'h0000_0008);
        settle();
        check("t2_count", 64'(wq.size()), 64'd4);
        pop_check("t2_w0", 32'h1122_3344, 1'b1, 1'b0);
        pop_check("t2_w1", 32'h0000_0011, 1'b0, 1'b1);
        pop_check("t2_w2", 32'hC0C1_C2C3, 1'b1, 1'b0);
        pop_check("t2_w3", 32'h0000_0008, 1'b0, 1'b1);
        check("t2_err_len", 64'(n_err_len - e0), 64'd1);

        // Overlong length (MAX_MSG_BYTES + 4).
        e0 = n_err_len;
        send_word(32'hD0D1_D2D3);
        send_word(32'h0000_0044);
        settle();
        check("t3_count", 64'(wq.size()), 64'd2);
        pop_check("t3_w0", 32'hD0D1_D2D3, 1'b1, 1'b0);
        pop_check("t3_w1", 32'h0000_0044, 1'b0, 1'b1);
        check("t3_err_len", 64'(n_err_len - e0), 64'd1);

        // Maximum legal length: 16 words, eop on the last only.
        e0 = n_err_len;
        send_word(32'hE0E1_E2E3);
        send_word(32'h0000_0040);
        for (int i = 2; i < 16; i++) send_word(32'h1000_0000 | 32'(i));
        settle();
        check("t4_count", 64'(wq.size()), 64'd16);
        pop_check("t4_w0", 32'hE0E1_E2E3, 1'b1, 1'b0);
        pop_check("t4_w1", 32'h0000_0040, 1'b0, 1'b0);
        for (int i = 2; i < 16; i++)
            pop_check($sformatf("t4_w%0d", i), 32'h1000_0000 | 32'(i), 1'b0, (i == 15));
        check("t4_err_len", 64'(n_err_len - e0), 64'd0);

        // Downstream stalls for 20 cycles mid-message.
        aso_task_ready = 1'b0;
        fork
            begin
                send_msg16(32'h5152_5354, 32'h6162_6364, 32'h7172_7374);
            end
            begin
                repeat (6) @(negedge clk);
                check("bp_byte_ready", 64'(asi_byte_ready), 64'd0);
                check("bp_word", {31'b0, aso_task_valid, aso_task_sop, aso_task_eop, aso_task_data},
                      {31'b0, 1'b1, 1'b1, 1'b0, 32'h5152_5354});
                repeat (14) @(negedge clk);
                check("bp_hold", {31'b0, aso_task_valid, aso_task_sop, aso_task_eop, aso_task_data},
                      {31'b0, 1'b1, 1'b1, 1'b0, 32'h5152_5354});
                @(posedge clk);
                #1;
                aso_task_ready = 1'b1;
            end
        join
        settle();
        check("bp_count", 64'(wq.size()), 64'd4);
        pop_check("bp_w0", 32'h5152_5354, 1'b1, 1'b0);
        pop_check("bp_w1", 32'h0000_0010, 1'b0, 1'b0);
        pop_check("bp_w2", 32'h6162_6364, 1'b0, 1'b0);
        pop_check("bp_w3", 32'h7172_7374, 1'b0, 1'b1);

        // Two messages back to back.
        send_msg16(32'h8182_8384, 32'h8586_8788, 32'h898A_8B8C);
        send_msg16(32'h9192_9394, 32'h9596_9798, 32'h999A_9B9C);
        settle();
        check("b2b_count", 64'(wq.size()), 64'd8);
        pop_check("b2b_w0", 32'h8182_8384, 1'b1, 1'b0);
        pop_check("b2b_w1", 32'h0000_0010, 1'b0, 1'b0);
        pop_check("b2b_w2", 32'h8586_8788, 1'b0, 1'b0);
        pop_check("b2b_w3", 32'h898A_8B8C, 1'b0, 1'b1);
        pop_check("b2b_w4", 32'h9192_9394, 1'b1, 1'b0);
        pop_check("b2b_w5", 32'h0000_0010, 1'b0, 1'b0);
        pop_check("b2b_w6", 32'h9596_9798, 1'b0, 1'b0);
        pop_check("b2b_w7", 32'h999A_9B9C, 1'b0, 1'b1);

`ifdef TASK_FRAMER_TIMEOUT_EN
        // Six bytes then silence: pad word closes the message.
        e0 = n_err_to;
        send_word(32'hAAAA_AAAA);
        send_byte(8'hBB);
        send_byte(8'hBB);
        repeat (20) @(posedge clk);
        #1;
        check("to_count", 64'(wq.size()), 64'd2);
        pop_check("to_w0", 32'hAAAA_AAAA, 1'b1, 1'b0);
        pop_check("to_pad", 32'hBBBB_0000, 1'b0, 1'b1);
        check("to_err", 64'(n_err_to - e0), 64'd1);
        send_msg16(32'hC1C2_C3C4, 32'hC5C6_C7C8, 32'hC9CA_CBCC);
        settle();
        check("to_next_count", 64'(wq.size()), 64'd4);
        pop_check("to_next_w0", 32'hC1C2_C3C4, 1'b1, 1'b0);
        pop_check("to_next_w1", 32'h0000_0010, 1'b0, 1'b0);
        pop_check("to_next_w2", 32'hC5C6_C7C8, 1'b0, 1'b0);
        pop_check("to_next_w3", 32'hC9CA_CBCC, 1'b0, 1'b1);
`endif

        // Reset mid-message discards the partial message.
        aso_task_ready = 1'b0;
        send_word(32'hF0F1_F2F3);
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_byte_ready", 64'(asi_byte_ready), 64'd0);
        check("rstmid_flags", 64'({aso_task_valid, aso_task_sop, aso_task_eop, err_len, err_timeout}), 64'd0);
        check("rstmid_data", 64'(aso_task_data), 64'd0);
        aso_task_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
        send_byte(8'hF4);
        send_byte(8'hF5);
        send_byte(8'hF6);
        send_byte(8'hF7);
        send_word(32'h0000_0010);
        send_word(32'h1314_1516);
        send_word(32'h1718_191A);
        settle();
        check("rstmid_count", 64'(wq.size()), 64'd4);
        pop_check("rstmid_w0", 32'hF4F5_F6F7, 1'b1, 1'b0);
        pop_check("rstmid_w1", 32'h0000_0010, 1'b0, 1'b0);
        pop_check("rstmid_w2", 32'h1314_1516, 1'b0, 1'b0);
        pop_check("rstmid_w3", 32'h1718_191A, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
